// File: rtl/serial_parity_pkg.sv
// Shared types and helpers for the serial parity framer.
package serial_parity_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  function automatic int cnt_w(input int width);
    if (width <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/parity_step.sv
// One-bit parity accumulate: a 2:1 mux picks acc or its inverse under the data bit.
module parity_step (
  input  logic bit_i,
  input  logic acc_i,
  output logic acc_o
);

  assign acc_o = bit_i ? (acc_i ? 1'b0 : 1'b1) : (acc_i ? 1'b1 : 1'b0);

endmodule

// File: rtl/serial_parity_framer.sv
// Collects LSB-first serial bits into WIDTH-bit frames and presents {frame, parity}
// on a valid/ready port with zero-bubble hand-off between frames.
module serial_parity_framer
  import serial_parity_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic             up_data,
  output logic             up_ready,
  output logic             down_valid,
  output logic [WIDTH-1:0] down_data,
  output logic             down_parity,
  input  logic             down_ready
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             parity_q, parity_d;
  logic             valid_q, valid_d;
  logic             accept_s, last_s, frame_done_s, acc_step_s;

  parity_step u_parity_step (
    .bit_i (up_data),
    .acc_i (acc_q),
    .acc_o (acc_step_s)
  );

  // Upstream ready: free in COLLECT, tied to consumer in HOLD so a bit can ride the hand-off.
  always_comb begin
    up_ready = 1'b1;
    case (state_q)
      COLLECT: up_ready = 1'b1;
      HOLD:    up_ready = down_ready;
      default: up_ready = 1'b1;
    endcase
  end

  // Datapath next-state: shift-in, counter, accumulator and output capture.
  always_comb begin
    accept_s     = up_valid & up_ready;
    last_s       = (cnt_q == LAST_IDX);
    frame_done_s = accept_s & last_s;

    for (int i = 0; i < WIDTH; i++) begin
      shreg_d[i] = (accept_s && (cnt_q == CW'(i))) ? up_data : shreg_q[i];
    end

    if (accept_s) begin
      cnt_d = last_s ? {CW{1'b0}} : (cnt_q + CW'(1));
      acc_d = last_s ? 1'b0 : acc_step_s;
    end else begin
      cnt_d = cnt_q;
      acc_d = acc_q;
    end

    if (frame_done_s) begin
      data_d   = shreg_d;
      parity_d = acc_step_s ^ ODD_PARITY;
    end else begin
      data_d   = data_q;
      parity_d = parity_q;
    end
  end

  // FSM next-state; WIDTH==1 can refill HOLD directly from the hand-off bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: state_d = frame_done_s ? HOLD : COLLECT;
      HOLD: begin
        if (down_ready) begin
          state_d = frame_done_s ? HOLD : COLLECT;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = COLLECT;
    endcase
    valid_d = (state_d == HOLD);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Bit counter and running parity.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
      acc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  // Frame shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= {WIDTH{1'b0}};
    end else begin
      shreg_q <= shreg_d;
    end
  end

  // Downstream output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= {WIDTH{1'b0}};
      parity_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      data_q   <= data_d;
      parity_q <= parity_d;
      valid_q  <= valid_d;
    end
  end

  assign down_valid  = valid_q;
  assign down_data   = data_q;
  assign down_parity = parity_q;

endmodule

// File: tb/tb_serial_parity_framer.sv
// Directed self-checking bench: 8-bit even/odd framers sharing stimulus, plus a 1-bit framer.
module tb_serial_parity_framer;

  logic clk = 1'b0;
  logic rst;
  logic up_valid, up_data, down_ready;
  logic up_ready_e, down_valid_e, down_parity_e;
  logic [7:0] down_data_e;
  logic up_ready_o, down_valid_o, down_parity_o;
  logic [7:0] down_data_o;
  logic u1_valid, u1_data, d1_ready;
  logic up_ready_1, down_valid_1, down_parity_1;
  logic [0:0] down_data_1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_parity_framer #(.WIDTH(8), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready_e),
    .down_valid(down_valid_e), .down_data(down_data_e), .down_parity(down_parity_e),
    .down_ready(down_ready));

  serial_parity_framer #(.WIDTH(8), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready_o),
    .down_valid(down_valid_o), .down_data(down_data_o), .down_parity(down_parity_o),
    .down_ready(down_ready));

  serial_parity_framer #(.WIDTH(1), .ODD_PARITY(1'b0)) dut_w1 (
    .clk(clk), .rst(rst), .up_valid(u1_valid), .up_data(u1_data), .up_ready(up_ready_1),
    .down_valid(down_valid_1), .down_data(down_data_1), .down_parity(down_parity_1),
    .down_ready(d1_ready));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic feed8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      up_valid = 1'b1;
      up_data  = v[i];
      cyc();
    end
    up_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; up_valid = 1'b0; up_data = 1'b0; down_ready = 1'b0;
    u1_valid = 1'b0; u1_data = 1'b0; d1_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if ({up_ready_e, down_valid_e, down_data_e, down_parity_e} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle_w8 cycle %0d: got rdy=%b vld=%b data=%h par=%b, expected rdy=1 vld=0 data=00 par=0",
                 i, up_ready_e, down_valid_e, down_data_e, down_parity_e);
      end
      checks++;
      if ({up_ready_1, down_valid_1, down_data_1, down_parity_1} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle_w1 cycle %0d: got rdy=%b vld=%b data=%b par=%b, expected 1 0 0 0",
                 i, up_ready_1, down_valid_1, down_data_1, down_parity_1);
      end
    end
  endtask

  task automatic test_basic;
    down_ready = 1'b1;
    feed8(8'h0D);
    checks++;
    if ({down_valid_e, down_data_e, down_parity_e} !== {1'b1, 8'h0D, 1'b1}) begin
      errors++;
      $display("FAIL basic_even: got vld=%b data=%h par=%b, expected vld=1 data=0d par=1",
               down_valid_e, down_data_e, down_parity_e);
    end
    checks++;
    if ({down_valid_o, down_data_o, down_parity_o} !== {1'b1, 8'h0D, 1'b0}) begin
      errors++;
      $display("FAIL basic_odd: got vld=%b data=%h par=%b, expected vld=1 data=0d par=0",
               down_valid_o, down_data_o, down_parity_o);
    end
    cyc();
    checks++;
    if (down_valid_e !== 1'b0) begin
      errors++;
      $display("FAIL basic_consume: got vld=%b expected 0", down_valid_e);
    end
  endtask

  task automatic test_backpressure;
    down_ready = 1'b0;
    feed8(8'hFF);
    checks++;
    if ({down_valid_e, down_data_e, down_parity_e, down_parity_o} !== {1'b1, 8'hFF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bp_present: got vld=%b data=%h par_e=%b par_o=%b, expected 1 ff 0 1",
               down_valid_e, down_data_e, down_parity_e, down_parity_o);
    end
    for (int k = 0; k < 5; k++) begin
      up_valid = ((k % 2) == 0);
      up_data  = 1'b0;
      #1;
      checks++;
      if (up_ready_e !== 1'b0) begin
        errors++;
        $display("FAIL bp_up_ready cycle %0d: got %b expected 0", k, up_ready_e);
      end
      cyc();
      checks++;
      if ({down_valid_e, down_data_e, down_parity_e} !== {1'b1, 8'hFF, 1'b0}) begin
        errors++;
        $display("FAIL bp_stable cycle %0d: got vld=%b data=%h par=%b, expected 1 ff 0",
                 k, down_valid_e, down_data_e, down_parity_e);
      end
    end
    up_valid   = 1'b0;
    down_ready = 1'b1;
    #1;
    checks++;
    if (up_ready_e !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b expected 1", up_ready_e);
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++;
      if (down_valid_e !== 1'b0) begin
        errors++;
        $display("FAIL bp_single_consume cycle %0d: got vld=%b expected 0", k, down_valid_e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rnd;
    logic [7:0]  exp_frame;
    int nf;
    rnd = $urandom;
    nf = 0;
    down_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      up_valid = 1'b1;
      up_data  = rnd[i];
      #1;
      checks++;
      if (up_ready_e !== 1'b1) begin
        errors++;
        $display("FAIL b2b_no_bubble bit %0d: got up_ready=%b expected 1", i, up_ready_e);
      end
      cyc();
      if (down_valid_e === 1'b1) begin
        exp_frame = (nf < 4) ? rnd[nf*8 +: 8] : 8'h00;
        checks++;
        if ({down_data_e, down_parity_e, down_parity_o} !== {exp_frame, ^exp_frame, ~^exp_frame}) begin
          errors++;
          $display("FAIL b2b_frame %0d: got data=%h par_e=%b par_o=%b, expected data=%h par_e=%b par_o=%b",
                   nf, down_data_e, down_parity_e, down_parity_o, exp_frame, ^exp_frame, ~^exp_frame);
        end
        nf++;
      end
    end
    up_valid = 1'b0;
    cyc();
    checks++;
    if (nf !== 4 || down_valid_e !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: got frames=%0d vld=%b, expected frames=4 vld=0", nf, down_valid_e);
    end
  endtask

  task automatic test_gaps;
    logic [7:0] v;
    v = 8'h6C;
    down_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_valid = 1'b1; up_data = v[i]; cyc();
    end
    up_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (down_valid_e !== 1'b0) begin
        errors++;
        $display("FAIL gap_idle cycle %0d: got vld=%b expected 0", k, down_valid_e);
      end
    end
    for (int i = 3; i < 8; i++) begin
      up_valid = 1'b1; up_data = v[i]; cyc();
    end
    up_valid = 1'b0;
    checks++;
    if ({down_valid_e, down_data_e, down_parity_e, down_parity_o} !== {1'b1, 8'h6C, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL gap_frame: got vld=%b data=%h par_e=%b par_o=%b, expected 1 6c 0 1",
               down_valid_e, down_data_e, down_parity_e, down_parity_o);
    end
    cyc();
  endtask

  task automatic test_reset_mid;
    down_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      up_valid = 1'b1; up_data = 1'b1; cyc();
    end
    up_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({down_valid_e, up_ready_e} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_state: got vld=%b rdy=%b, expected vld=0 rdy=1", down_valid_e, up_ready_e);
    end
    feed8(8'hA5);
    checks++;
    if ({down_valid_e, down_data_e, down_parity_e} !== {1'b1, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_frame: got vld=%b data=%h par=%b, expected 1 a5 0",
               down_valid_e, down_data_e, down_parity_e);
    end
    cyc();
    down_ready = 1'b0;
    feed8(8'h33);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({down_valid_e, down_data_e, down_parity_e} !== {1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL rst_hold_drop: got vld=%b data=%h par=%b, expected 0 00 0",
               down_valid_e, down_data_e, down_parity_e);
    end
    down_ready = 1'b1;
  endtask

  task automatic test_width1;
    logic [2:0] bits;
    bits = 3'b101;
    d1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      u1_valid = 1'b1;
      u1_data  = bits[i];
      #1;
      checks++;
      if (up_ready_1 !== 1'b1) begin
        errors++;
        $display("FAIL w1_ready bit %0d: got %b expected 1", i, up_ready_1);
      end
      cyc();
      checks++;
      if ({down_valid_1, down_data_1, down_parity_1} !== {1'b1, bits[i], bits[i]}) begin
        errors++;
        $display("FAIL w1_frame %0d: got vld=%b data=%b par=%b, expected vld=1 data=%b par=%b",
                 i, down_valid_1, down_data_1, down_parity_1, bits[i], bits[i]);
      end
    end
    u1_valid = 1'b0;
    cyc();
    checks++;
    if (down_valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_drain: got vld=%b expected 0", down_valid_1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_parity_framer.md
# serial_parity_framer

Collects a serial bit stream into fixed-width frames and computes a parity bit for each frame. Each accumulation step is a one-bit XOR built from a mux. The block sits directly downstream of the single-bit XOR/mux primitives. It drives a parallel valid/ready consumer with {frame, parity}.

## Interface
- `WIDTH`, default 8: bits per frame; legal range 1..64.
- `ODD_PARITY`, default 0: 0 selects even parity (parity bit = XOR of all frame bits); 1 selects odd parity (inverted XOR).
- `clk`  input  1  : single clock; all state updates on the rising edge.
- `rst`  input  1  : reset; synchronous, active-high.
- `up_valid`  input  1  : `up_data` is valid this cycle.
- `up_data`  input  1  : serial data bit.
- `up_ready`  output  1  : block accepts a bit this cycle.
- `down_valid`  output  1  : a completed frame is presented.
- `down_data`  output  WIDTH  : frame; the first bit accepted lands in bit 0 (LSB-first).
- `down_parity`  output  1  : parity of `down_data` per `ODD_PARITY`.
- `down_ready`  input  1  : consumer takes the frame this cycle.

## Operation
- A bit transfers when `up_valid && up_ready`. A frame transfers when `down_valid && down_ready`.
- State machine states:
  - COLLECT: `up_ready`=1, `down_valid`=0.
  - HOLD: `down_valid`=1; `up_ready` = `down_ready`.
- Per accepted bit:
  - shift register bit[cnt] <= `up_data`;
  - acc <= acc ^ `up_data`;
  - cnt <= cnt+1.
- COLLECT -> HOLD when the accepted bit has cnt == WIDTH-1. On that transition:
  - the frame and acc are latched to the output registers;
  - cnt and acc clear.
- HOLD with `down_ready`=0: outputs remain stable; `up_valid` is ignored.
- HOLD with `down_ready`=1:
  - the frame is consumed;
  - if `up_valid`=1 in the same cycle, that bit is accepted as bit 0 of the next frame. This gives zero-bubble back-to-back frames.
  - If WIDTH==1 and a bit is accepted in this cycle, the state stays HOLD with the new frame. Otherwise the state goes to COLLECT.
- `down_parity` = acc_final ^ `ODD_PARITY`.
- Counter width is max(1, $clog2(WIDTH)). cnt never exceeds WIDTH-1; wrap to 0 is explicit, not by overflow.
- Unused shift-register bits are don't-care internally. `down_data` is fully written before `down_valid` rises.

## Timing
- Reset values:
  - state=COLLECT, cnt=0, acc=0;
  - `up_ready`=1, `down_valid`=0, `down_data`=0, `down_parity`=0.
- Reset mid-frame discards the partial frame. Reset during HOLD drops the held frame. No partial frame is ever emitted.
- Latency: `down_valid` rises the cycle after the WIDTH-th bit is accepted.
- Throughput: 1 bit/cycle sustained while `down_ready` is held 1.
- `up_ready` in HOLD depends combinationally on `down_ready`. All other outputs are registered.
- `up_valid` deasserting mid-frame stalls the frame. Gaps of any length are legal and do not alter contents.

## Structure
- Package `serial_parity_pkg`: the state enum `state_t` {COLLECT, HOLD}, plus the function `cnt_w(width)` returning max(1, $clog2(width)).
- Sub-module `parity_step`: purely combinational one-bit accumulate, acc_next = bit ? ~acc : acc, built from a 2:1 mux with constants. Instantiate it once in the accumulator path.
- Top: FSM, counter, shift register and output registers in separate always_ff blocks. Next-state and ready logic go in always_comb.

## Test plan
- Reset, then idle: `up_ready`=1, `down_valid`=0, all outputs 0 for 10 cycles.
- WIDTH=8, even parity: feed 1,0,1,1,0,0,0,0 back-to-back with `down_ready`=1.
  - Next cycle: `down_valid`=1, `down_data`=8'h0D, `down_parity`=1.
  - With ODD_PARITY=1: same frame, `down_parity`=0.
- Backpressure: complete frame 8'hFF with `down_ready`=0 for 5 cycles.
  - `down_data`=8'hFF and `down_parity`=0 stay stable.
  - `up_ready`=0; `up_valid` pulses are ignored.
  - Release `down_ready`: exactly one frame is consumed.
- Back-to-back: stream 32 random bits continuously with `down_ready`=1.
  - Four frames, each matching the scoreboard.
  - No idle cycles on `up_ready`.
- Mid-frame gaps and reset:
  - Feed 3 bits, drop `up_valid` for 4 cycles, resume 5 bits: a single correct frame.
  - Separately, feed 5 bits, assert `rst` for 1 cycle, then feed 8'hA5 LSB-first: `down_data`=8'hA5, `down_parity`=0.
- WIDTH=1: alternate bits 1,0,1 with `down_ready`=1.
  - Consecutive frames {1,p=1}, {0,p=0}, {1,p=1}.
  - `down_valid` is held high continuously.
